noise_lfsr_gen: RTL and testbench

NOISE_LFSR_GEN -- requirements
Module: noise_lfsr_gen

---
 rtl/noise_lfsr_gen.sv | 102 ++++++++++
 tb/tb_noise_lfsr_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_lfsr_gen.sv
// Noise channel generator: a clock-enabled LFSR stepped by a programmable
// divider, gated by a volume envelope that is driven by an external tick.
module noise_lfsr_gen #(
    parameter int LFSR_W = 15,
    parameter int OUT_W  = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk50mhz,
    input  logic              rst_n,
    input  logic              en,
    input  logic              trigger,
    input  logic [DIV_W-1:0]  period,
    input  logic              short_mode,
    input  logic [OUT_W-1:0]  env_init,
    input  logic              env_dir,
    input  logic [2:0]        env_period,
    input  logic              env_tick,
    output logic [OUT_W-1:0]  noise_out,
    output logic              step,
    output logic [OUT_W-1:0]  volume,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam logic [LFSR_W-1:0] LFSR_ONES = {LFSR_W{1'b1}};
    localparam logic [OUT_W-1:0]  VOL_MAX   = {OUT_W{1'b1}};

    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] s_shift;
    logic [LFSR_W-1:0] s_step;
    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        env_cnt;
    logic [OUT_W-1:0]  vol_next;
    logic              fb;
    logic              div_done;
    logic              env_hit;
    logic              env_wrap;

    assign div_done = en && (div_cnt == '0);
    assign env_hit  = en && env_tick && (env_period != 3'd0);
    // Counter is widened so that env_cnt = 7 plus one cannot wrap before the compare.
    assign env_wrap = ({1'b0, env_cnt} + 4'd1) >= {1'b0, env_period};

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        fb      = s[0] ^ s[1];
        s_shift = {fb, s[LFSR_W-1:1]};
        if (short_mode) begin
            s_shift[6] = fb;
        end
        s_step = (s == '0) ? LFSR_ONES : s_shift;
    end

    always_comb begin
        vol_next = volume;
        if (env_dir) begin
            if (volume != VOL_MAX) vol_next = volume + OUT_W'(1);
        end else begin
            if (volume != '0) vol_next = volume - OUT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            s         <= LFSR_ONES;
            div_cnt   <= '0;
            env_cnt   <= '0;
            volume    <= '0;
            noise_out <= '0;
            step      <= 1'b0;
        end else begin
            noise_out <= (en && !s[0]) ? volume : '0;
            if (trigger) begin
                // A note start wins over any coincident divider expiry or envelope tick.
                s       <= LFSR_ONES;
                div_cnt <= period;
                volume  <= env_init;
                env_cnt <= '0;
                step    <= 1'b0;
            end else begin
                step <= div_done;
                if (div_done) begin
                    s       <= s_step;
                    div_cnt <= period;
                end else if (en) begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end
                if (env_hit) begin
                    if (env_wrap) begin
                        env_cnt <= '0;
                        volume  <= vol_next;
                    end else begin
                        env_cnt <= env_cnt + 3'd1;
                    end
                end
            end
        end
    end

    assign lfsr_state = s;

endmodule

// File: tb/tb_noise_lfsr_gen.sv
// Self-checking bench for noise_lfsr_gen: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_noise_lfsr_gen;

    localparam int LFSR_W = 15;
    localparam int OUT_W  = 4;
    localparam int DIV_W  = 16;
    localparam logic [LFSR_W-1:0] ONES = {LFSR_W{1'b1}};
    localparam int VOL_MAX = (1 << OUT_W) - 1;

    logic              clk50mhz;
    logic              rst_n;
    logic              en;
    logic              trigger;
    logic [DIV_W-1:0]  period;
    logic              short_mode;
    logic [OUT_W-1:0]  env_init;
    logic              env_dir;
    logic [2:0]        env_period;
    logic              env_tick;
    logic [OUT_W-1:0]  noise_out;
    logic              step;
    logic [OUT_W-1:0]  volume;
    logic [LFSR_W-1:0] lfsr_state;

    int checks   = 0;
    int failures = 0;

    noise_lfsr_gen #(.LFSR_W(LFSR_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
        .clk50mhz   (clk50mhz),
        .rst_n      (rst_n),
        .en         (en),
        .trigger    (trigger),
        .period     (period),
        .short_mode (short_mode),
        .env_init   (env_init),
        .env_dir    (env_dir),
        .env_period (env_period),
        .env_tick   (env_tick),
        .noise_out  (noise_out),
        .step       (step),
        .volume     (volume),
        .lfsr_state (lfsr_state)
    );

    initial clk50mhz = 1'b0;
    always #10 clk50mhz = ~clk50mhz;

    // Reference next-state of the noise register, written as plain arithmetic.
    function automatic logic [LFSR_W-1:0] model_lfsr(input logic [LFSR_W-1:0] cur, input logic sm);
        logic [LFSR_W-1:0] n;
        logic [LFSR_W-1:0] fbv;
        if (cur == '0) return ONES;
        fbv = (cur ^ (cur >> 1)) & LFSR_W'(1);
        n = (cur >> 1) | (fbv << (LFSR_W - 1));
        if (sm) n = (n & ~(LFSR_W'(1) << 6)) | (fbv << 6);
        return n;
    endfunction

    task automatic drive_idle();
        en         = 1'b0;
        trigger    = 1'b0;
        period     = '0;
        short_mode = 1'b0;
        env_init   = '0;
        env_dir    = 1'b0;
        env_period = 3'd0;
        env_tick   = 1'b0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk50mhz);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk50mhz);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk50mhz);
        rst_n = 1'b0;
        drive_idle();
        #1;
        checks++;
        if (lfsr_state !== ONES || step !== 1'b0 || volume !== '0 || noise_out !== '0) begin
            failures++;
            $display("FAIL reset: lfsr=%h step=%b vol=%0d noise=%0d, want lfsr=%h step=0 vol=0 noise=0",
                     lfsr_state, step, volume, noise_out, ONES);
        end
        repeat (2) @(negedge clk50mhz);
        rst_n = 1'b1;
    endtask

    task automatic test_first_step(input logic sm, input logic [LFSR_W-1:0] want);
        do_reset();
        short_mode = sm;
        en = 1'b1;
        @(posedge clk50mhz);
        #1;
        checks++;
        if (lfsr_state !== want || step !== 1'b1) begin
            failures++;
            $display("FAIL first_step sm=%b: lfsr=%h step=%b, want lfsr=%h step=1", sm, lfsr_state, step, want);
        end
        checks++;
        if (noise_out !== '0) begin
            failures++;
            $display("FAIL first_step_noise sm=%b: noise=%0d, want 0", sm, noise_out);
        end
        @(negedge clk50mhz);
        en = 1'b0;
    endtask

    task automatic test_divider();
        logic want;
        do_reset();
        period = DIV_W'(3);
        for (int e = 0; e < 28; e++) begin
            en = !(e >= 14 && e <= 18);
            @(posedge clk50mhz);
            #1;
            want = (e == 0 || e == 4 || e == 8 || e == 12 || e == 21 || e == 25);
            checks++;
            if (step !== want) begin
                failures++;
                $display("FAIL divider edge %0d: step=%b, want %b", e, step, want);
            end
            @(negedge clk50mhz);
        end
        en = 1'b0;
    endtask

    task automatic env_run(input int init, input logic dir, input int ticks);
        int want;
        env_init   = OUT_W'(init);
        env_dir    = dir;
        env_period = 3'd2;
        trigger    = 1'b1;
        @(posedge clk50mhz);
        #1;
        checks++;
        if (volume !== OUT_W'(init)) begin
            failures++;
            $display("FAIL env_load: vol=%0d, want %0d", volume, init);
        end
        @(negedge clk50mhz);
        trigger = 1'b0;
        for (int t = 1; t <= ticks; t++) begin
            env_tick = 1'b1;
            @(posedge clk50mhz);
            #1;
            want = dir ? init + t / 2 : init - t / 2;
            if (want > VOL_MAX) want = VOL_MAX;
            if (want < 0) want = 0;
            checks++;
            if (volume !== OUT_W'(want)) begin
                failures++;
                $display("FAIL env dir=%b tick %0d: vol=%0d, want %0d", dir, t, volume, want);
            end
            @(negedge clk50mhz);
            env_tick = 1'b0;
            @(negedge clk50mhz);
        end
    endtask

    task automatic test_envelope();
        do_reset();
        en     = 1'b1;
        period = '1;
        env_run(8, 1'b0, 20);
        env_run(14, 1'b1, 6);
        en = 1'b0;
    endtask

    task automatic test_lockup();
        bit seen;
        do_reset();
        en      = 1'b1;
        period  = DIV_W'(40);
        trigger = 1'b1;
        @(negedge clk50mhz);
        trigger = 1'b0;
        force dut.s = '0;
        #1;
        release dut.s;
        @(posedge clk50mhz);
        #1;
        checks++;
        if (lfsr_state !== '0) begin
            failures++;
            $display("FAIL lockup_zero: lfsr=%h, want 0", lfsr_state);
        end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk50mhz);
            #1;
            if (step === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lfsr_state !== ONES) begin
            failures++;
            $display("FAIL lockup_recover: step_seen=%b lfsr=%h, want step and lfsr=%h", seen, lfsr_state, ONES);
        end
        @(negedge clk50mhz);
        en = 1'b0;
    endtask

    task automatic test_trigger_priority();
        do_reset();
        en         = 1'b1;
        period     = '0;
        env_init   = OUT_W'(5);
        env_period = 3'd1;
        trigger    = 1'b1;
        @(negedge clk50mhz);
        trigger = 1'b0;
        repeat (3) @(negedge clk50mhz);
        env_init = OUT_W'(9);
        trigger  = 1'b1;
        env_tick = 1'b1;
        @(posedge clk50mhz);
        #1;
        checks++;
        if (lfsr_state !== ONES || volume !== OUT_W'(9) || step !== 1'b0) begin
            failures++;
            $display("FAIL trigger_priority: lfsr=%h vol=%0d step=%b, want lfsr=%h vol=9 step=0",
                     lfsr_state, volume, step, ONES);
        end
        @(negedge clk50mhz);
        trigger  = 1'b0;
        env_tick = 1'b0;
        repeat (2) @(negedge clk50mhz);
        checks++;
        if (step !== 1'b1 || volume !== OUT_W'(9)) begin
            failures++;
            $display("FAIL pre_reset: step=%b vol=%0d, want step=1 vol=9", step, volume);
        end
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (noise_out !== '0 || step !== 1'b0 || volume !== '0 || lfsr_state !== ONES) begin
            failures++;
            $display("FAIL mid_reset: noise=%0d step=%b vol=%0d lfsr=%h, want 0/0/0/%h",
                     noise_out, step, volume, lfsr_state, ONES);
        end
        @(negedge clk50mhz);
        rst_n = 1'b1;
        drive_idle();
    endtask

    task automatic test_random();
        logic [LFSR_W-1:0] m_s;
        int m_target, m_elapsed, m_ticks, m_vol, m_noise, m_step;
        int local_fail;
        do_reset();
        m_s = ONES; m_target = 0; m_elapsed = 0; m_ticks = 0;
        m_vol = 0; m_noise = 0; m_step = 0;
        local_fail = 0;
        for (int cyc = 0; cyc < 3000 && local_fail < 10; cyc++) begin
            trigger  = ($urandom_range(0, 39) == 0);
            en       = ($urandom_range(0, 7) != 0);
            env_tick = ($urandom_range(0, 2) == 0);
            env_init = OUT_W'($urandom);
            if ($urandom_range(0, 19) == 0) period = DIV_W'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) begin
                env_period = 3'($urandom_range(0, 7));
                env_dir    = 1'($urandom);
            end
            if ($urandom_range(0, 99) == 0) short_mode = ~short_mode;

            // Output register samples the pre-edge sequence and volume.
            m_noise = (en && (m_s % 2 == 0)) ? m_vol : 0;
            if (trigger) begin
                m_s = ONES; m_target = int'(period); m_elapsed = 0;
                m_vol = int'(env_init); m_ticks = 0; m_step = 0;
            end else begin
                m_step = 0;
                if (en) begin
                    if (m_elapsed == m_target) begin
                        m_step = 1;
                        m_s = model_lfsr(m_s, short_mode);
                        m_elapsed = 0;
                        m_target = int'(period);
                    end else begin
                        m_elapsed++;
                    end
                end
                if (en && env_tick && env_period != 3'd0) begin
                    m_ticks++;
                    if (m_ticks >= int'(env_period)) begin
                        m_ticks = 0;
                        m_vol = env_dir ? m_vol + 1 : m_vol - 1;
                        if (m_vol > VOL_MAX) m_vol = VOL_MAX;
                        if (m_vol < 0) m_vol = 0;
                    end
                end
            end

            @(posedge clk50mhz);
            #1;
            checks++;
            if (lfsr_state !== m_s) begin
                failures++; local_fail++;
                $display("FAIL rand_lfsr cyc %0d: got %h, want %h", cyc, lfsr_state, m_s);
            end
            checks++;
            if (step !== 1'(m_step)) begin
                failures++; local_fail++;
                $display("FAIL rand_step cyc %0d: got %b, want %0d", cyc, step, m_step);
            end
            checks++;
            if (volume !== OUT_W'(m_vol)) begin
                failures++; local_fail++;
                $display("FAIL rand_volume cyc %0d: got %0d, want %0d", cyc, volume, m_vol);
            end
            checks++;
            if (noise_out !== OUT_W'(m_noise)) begin
                failures++; local_fail++;
                $display("FAIL rand_noise cyc %0d: got %0d, want %0d", cyc, noise_out, m_noise);
            end
            @(negedge clk50mhz);
        end
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();
        test_reset();
        test_first_step(1'b0, 15'h3FFF);
        test_first_step(1'b1, 15'h3FBF);
        test_divider();
        test_envelope();
        test_lockup();
        test_trigger_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
